lane_rr_scheduler: RTL and testbench
====================================

# lane_rr_scheduler

Round-robin lane scheduler that merges four 8-bit byte lanes onto one serialized byte stream, and drives the lane-index selectors used by the mux/demux chain. It holds one byte per lane and applies valid/ready backpressure toward the lane sources. After reset it emits a fixed run of idle symbols before opening the lanes. It sits in the transmit path between the lane sources and the serialized link, and replaces testbench-driven selector generation.

## Interface
- SYNC_LEN, 4: idle cycles emitted after reset before lanes open; legal range 1..255.
- IDLE_SYM, 8'hBC: byte driven on dataOut whenever validOut=0.
- BURST_MAX, 2: maximum consecutive grants to one lane. Used only with SCHED_BURST_EN; legal range 1..15.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- dataIn0..dataIn3  in  8  lane k byte.
- validIn0..validIn3  in  1  lane k byte offered.
- readyIn0..readyIn3  out  1  lane k byte accepted this cycle when validIn_k is also high.
- dataOut  out  8  scheduled byte (registered).
- validOut  out  1  dataOut carries a lane byte (registered).
- selector0  out  1  lane index bit 0 of the current dataOut (registered).
- selector1  out  1  lane index bit 1 of the current dataOut (registered).
- syncDone  out  1  high once the SYNC phase has ended (registered).

## Operation
- Per-lane state: hold_k[7:0] and full_k. Shared state: round-robin pointer ptr[1:0], sync counter, and state register {SYNC, RUN}.
- SYNC state:
  - readyIn all 0; validOut=0; dataOut=IDLE_SYM.
  - The counter increments once per cycle. When it reaches SYNC_LEN the block moves to RUN and sets syncDone=1.
  - Once in RUN, the block stays in RUN until reset.
- RUN grant:
  - grant g is the first lane with full=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - g depends only on registered state. There is no combinational path from validIn to grant.
- readyIn_k = RUN & (~full_k | (grant valid & g==k)).
- Capture: when validIn_k & readyIn_k, set hold_k<=dataIn_k and full_k<=1.
  - Capture and grant on the same lane in the same cycle leaves full_k=1 with the new byte.
- On grant: dataOut<=hold_g; validOut<=1; {selector1,selector0}<=g; full_g cleared unless refilled that cycle; ptr<=g+1 (wraps 3->0).
- No lane full in RUN: validOut<=0; dataOut<=IDLE_SYM; selectors and ptr hold their values.
- Sources must hold validIn_k and dataIn_k stable until readyIn_k=1. A byte offered while readyIn_k=0 is not captured.
- Reset assertion, including mid-operation:
  - all held bytes are discarded, full=0, ptr=0, state=SYNC, counter=0;
  - outputs take reset values immediately (asynchronously).

## Timing
- Reset values: dataOut=IDLE_SYM, validOut=0, selector0=0, selector1=0, syncDone=0, readyIn0..3=0.
- After reset deasserts, syncDone rises at the SYNC_LEN-th rising edge. readyIn may assert in the following cycle.
- Latency: a byte captured at edge N appears on dataOut after edge N+1 at the earliest; with contention it waits for its turn.
- Throughput: one byte per cycle on dataOut. A single active lane sustains one byte per cycle because it is refilled on the cycle it is granted.
- Fairness: with all four lanes continuously full, each lane is granted exactly once per 4 cycles (without the macro).

## Configuration
- SCHED_BURST_EN defined:
  - a 4-bit burst counter is added;
  - after a grant, ptr stays at g while lane g remains full and fewer than BURST_MAX consecutive grants have gone to g;
  - once BURST_MAX is reached, or lane g is not full, ptr<=g+1 and the burst counter clears.
- SCHED_BURST_EN undefined: strict single-grant rotation (ptr<=g+1 on every grant); BURST_MAX is ignored.

## Test plan
- Reset then release, SYNC_LEN=4, all validIn=1 → readyIn=0 and dataOut=8'hBC for 4 cycles; syncDone=1 after the 4th edge; first valid byte 2 edges later.
- All lanes continuously valid with 8'h10/8'h20/8'h30/8'h40 → dataOut 10,20,30,40 repeating; selectors 0,1,2,3; validOut held at 1.
- Only lane 2 valid with incrementing bytes 8'h00.. → dataOut 00,01,02,… every cycle; selectors=2; readyIn2 continuously 1.
- Lanes 0 and 1 continuously valid, SCHED_BURST_EN defined, BURST_MAX=2 → lane order 0,0,1,1,0,0; without the macro → 0,1,0,1.
- Lane 3 holds 8'hAA, reset pulsed mid-run → validOut=0 and dataOut=8'hBC immediately; 8'hAA never appears after the SYNC phase.
- All lanes idle in RUN after last grant on lane 1 → validOut=0, dataOut=8'hBC, selectors stay at 1.

Source files
------------

// File: rtl/lane_rr_scheduler_if.sv
// lane_rr_scheduler_if
//   Bundles the four lane handshakes and the serialized output of lane_rr_scheduler.
//   Signals:
//     dataIn0..3   [7:0]  lane byte from source
//     validIn0..3         lane byte offered
//     readyIn0..3         lane byte accepted this cycle (when validIn also high)
//     dataOut      [7:0]  scheduled byte, IDLE_SYM when validOut=0
//     validOut            dataOut carries a lane byte
//     selector0/1         lane index of the current dataOut
//     syncDone            post-reset idle run has finished
//   Modports: master = lane sources / link side, slave = scheduler.
interface lane_rr_scheduler_if;
    logic [7:0] dataIn0;
    logic [7:0] dataIn1;
    logic [7:0] dataIn2;
    logic [7:0] dataIn3;
    logic       validIn0;
    logic       validIn1;
    logic       validIn2;
    logic       validIn3;
    logic       readyIn0;
    logic       readyIn1;
    logic       readyIn2;
    logic       readyIn3;
    logic [7:0] dataOut;
    logic       validOut;
    logic       selector0;
    logic       selector1;
    logic       syncDone;

    modport master (
        output dataIn0, dataIn1, dataIn2, dataIn3,
        output validIn0, validIn1, validIn2, validIn3,
        input  readyIn0, readyIn1, readyIn2, readyIn3,
        input  dataOut, validOut, selector0, selector1, syncDone
    );

    modport slave (
        input  dataIn0, dataIn1, dataIn2, dataIn3,
        input  validIn0, validIn1, validIn2, validIn3,
        output readyIn0, readyIn1, readyIn2, readyIn3,
        output dataOut, validOut, selector0, selector1, syncDone
    );
endinterface

// File: rtl/lane_rr_scheduler.sv
// lane_rr_scheduler
//   Round-robin merge of four 8-bit byte lanes onto one serialized byte stream. Each lane
//   has a one-byte holding register with valid/ready backpressure. After reset the block
//   emits SYNC_LEN idle symbols, then grants the first full lane starting at the
//   round-robin pointer, one byte per cycle.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    lane_rr_scheduler_if.slave (lane handshakes, dataOut/validOut,
//            selector0/1, syncDone)
//   Parameters:
//     SYNC_LEN   idle cycles after reset (1..255)
//     IDLE_SYM   byte driven when validOut=0
//     BURST_MAX  consecutive grants per lane (1..15), only with SCHED_BURST_EN
//   Build option:
//     SCHED_BURST_EN  when defined, a lane that stays full keeps the pointer for up to
//                     BURST_MAX consecutive grants; otherwise strict single-grant rotation.
module lane_rr_scheduler #(
    parameter int unsigned SYNC_LEN  = 4,
    parameter logic [7:0]  IDLE_SYM  = 8'hBC,
    parameter int unsigned BURST_MAX = 2
) (
    input logic                clk,
    input logic                reset,
    lane_rr_scheduler_if.slave bus
);

    if (SYNC_LEN < 1 || SYNC_LEN > 255) begin : gBadSyncLen
        $error("lane_rr_scheduler: SYNC_LEN must be in 1..255");
    end
    if (BURST_MAX < 1 || BURST_MAX > 15) begin : gBadBurstMax
        $error("lane_rr_scheduler: BURST_MAX must be in 1..15");
    end

    typedef enum logic [0:0] {StSync, StRun} stateT;

    stateT           stateQ, stateD;
    logic [7:0]      syncCntQ, syncCntD;
    logic [3:0][7:0] holdQ, holdD;
    logic [3:0]      fullQ, fullD;
    logic [1:0]      ptrQ, ptrD;
    logic [7:0]      dataOutQ, dataOutD;
    logic            validOutQ, validOutD;
    logic [1:0]      selQ, selD;
    logic            syncDoneQ, syncDoneD;
`ifdef SCHED_BURST_EN
    logic [3:0]      burstQ, burstD;
`endif

    logic [3:0][7:0] dataIn;
    logic [3:0]      validIn;
    logic [3:0]      readyIn;
    logic            grantValid;
    logic [1:0]      grantLane;

    assign dataIn  = {bus.dataIn3, bus.dataIn2, bus.dataIn1, bus.dataIn0};
    assign validIn = {bus.validIn3, bus.validIn2, bus.validIn1, bus.validIn0};

    // Grant uses registered state only, so validIn never reaches readyIn combinationally.
    always_comb begin
        grantValid = 1'b0;
        grantLane  = ptrQ;
        for (int i = 0; i < 4; i++) begin
            if (!grantValid && fullQ[ptrQ + 2'(i)]) begin
                grantValid = 1'b1;
                grantLane  = ptrQ + 2'(i);
            end
        end
    end

    // A lane being granted this cycle can be refilled in the same cycle.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            readyIn[k] = (stateQ == StRun) &&
                         (!fullQ[k] || (grantValid && (grantLane == 2'(k))));
        end
    end

    always_comb begin
        stateD    = stateQ;
        syncCntD  = syncCntQ;
        holdD     = holdQ;
        fullD     = fullQ;
        ptrD      = ptrQ;
        dataOutD  = dataOutQ;
        validOutD = validOutQ;
        selD      = selQ;
        syncDoneD = syncDoneQ;
`ifdef SCHED_BURST_EN
        burstD    = burstQ;
`endif

        unique case (stateQ)
            StSync: begin
                dataOutD  = IDLE_SYM;
                validOutD = 1'b0;
                syncCntD  = syncCntQ + 8'd1;
                if (syncCntQ == 8'(SYNC_LEN - 1)) begin
                    stateD    = StRun;
                    syncDoneD = 1'b1;
                end
            end
            StRun: begin
                if (grantValid) begin
                    dataOutD         = holdQ[grantLane];
                    validOutD        = 1'b1;
                    selD             = grantLane;
                    fullD[grantLane] = 1'b0;
                end else begin
                    dataOutD  = IDLE_SYM;
                    validOutD = 1'b0;
                end

                // Capture after the grant clear so a same-cycle refill keeps the lane full.
                for (int k = 0; k < 4; k++) begin
                    if (validIn[k] && readyIn[k]) begin
                        holdD[k] = dataIn[k];
                        fullD[k] = 1'b1;
                    end
                end

                if (grantValid) begin
`ifdef SCHED_BURST_EN
                    // Stay on the lane while it refills and its burst has room.
                    if (fullD[grantLane] && ((burstQ + 4'd1) < 4'(BURST_MAX))) begin
                        ptrD   = grantLane;
                        burstD = burstQ + 4'd1;
                    end else begin
                        ptrD   = grantLane + 2'd1;
                        burstD = 4'd0;
                    end
`else
                    ptrD = grantLane + 2'd1;
`endif
                end
            end
            default: begin
                stateD = StSync;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= StSync;
            syncCntQ  <= 8'd0;
            holdQ     <= '0;
            fullQ     <= 4'd0;
            ptrQ      <= 2'd0;
            dataOutQ  <= IDLE_SYM;
            validOutQ <= 1'b0;
            selQ      <= 2'd0;
            syncDoneQ <= 1'b0;
`ifdef SCHED_BURST_EN
            burstQ    <= 4'd0;
`endif
        end else begin
            stateQ    <= stateD;
            syncCntQ  <= syncCntD;
            holdQ     <= holdD;
            fullQ     <= fullD;
            ptrQ      <= ptrD;
            dataOutQ  <= dataOutD;
            validOutQ <= validOutD;
            selQ      <= selD;
            syncDoneQ <= syncDoneD;
`ifdef SCHED_BURST_EN
            burstQ    <= burstD;
`endif
        end
    end

    assign bus.readyIn0  = readyIn[0];
    assign bus.readyIn1  = readyIn[1];
    assign bus.readyIn2  = readyIn[2];
    assign bus.readyIn3  = readyIn[3];
    assign bus.dataOut   = dataOutQ;
    assign bus.validOut  = validOutQ;
    assign bus.selector0 = selQ[0];
    assign bus.selector1 = selQ[1];
    assign bus.syncDone  = syncDoneQ;

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Self-checking bench for lane_rr_scheduler: directed scenarios plus a randomized run
// checked against a lane/queue-level reference model.
module tb_lane_rr_scheduler;

    localparam int unsigned SyncLen  = 4;
    localparam logic [7:0]  Idle     = 8'hBC;
    localparam int unsigned BurstMax = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lane_rr_scheduler_if bus ();

    lane_rr_scheduler #(
        .SYNC_LEN (SyncLen),
        .IDLE_SYM (Idle),
        .BURST_MAX(BurstMax)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] dIn [4];
    logic [3:0] vIn;

    assign bus.dataIn0  = dIn[0];
    assign bus.dataIn1  = dIn[1];
    assign bus.dataIn2  = dIn[2];
    assign bus.dataIn3  = dIn[3];
    assign bus.validIn0 = vIn[0];
    assign bus.validIn1 = vIn[1];
    assign bus.validIn2 = vIn[2];
    assign bus.validIn3 = vIn[3];

    wire [3:0] rdy = {bus.readyIn3, bus.readyIn2, bus.readyIn1, bus.readyIn0};
    wire [1:0] sel = {bus.selector1, bus.selector0};

    int checks = 0;
    int failures = 0;

    // Reference model: per-lane one-byte slot, rotating search start, idle-run counter.
    bit         mRun;
    int         mCnt;
    bit         mFull [4];
    logic [7:0] mHold [4];
    int         mPtr;
    int         mBurst;
    logic [7:0] mData;
    bit         mValid;
    int         mSel;
    bit         mDone;

    function automatic void model_reset();
        mRun = 0; mCnt = 0; mPtr = 0; mBurst = 0;
        mData = Idle; mValid = 0; mSel = 0; mDone = 0;
        for (int k = 0; k < 4; k++) mFull[k] = 0;
    endfunction

    function automatic int model_grant();
        for (int i = 0; i < 4; i++) begin
            if (mFull[(mPtr + i) % 4]) return (mPtr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        int g;
        g = model_grant();
        for (int k = 0; k < 4; k++) r[k] = mRun && (!mFull[k] || g == k);
        return r;
    endfunction

    function automatic void model_step();
        logic [3:0] r;
        int g;
        r = model_ready();
        if (!mRun) begin
            mCnt++;
            if (mCnt == SyncLen) begin
                mRun = 1;
                mDone = 1;
            end
            return;
        end
        g = model_grant();
        if (g >= 0) begin
            mData = mHold[g]; mValid = 1; mSel = g; mFull[g] = 0;
        end else begin
            mData = Idle; mValid = 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (vIn[k] && r[k]) begin
                mHold[k] = dIn[k];
                mFull[k] = 1;
            end
        end
        if (g >= 0) begin
`ifdef SCHED_BURST_EN
            if (mFull[g] && mBurst + 1 < int'(BurstMax)) begin
                mBurst++;
                mPtr = g;
            end else begin
                mBurst = 0;
                mPtr = (g + 1) % 4;
            end
`else
            mPtr = (g + 1) % 4;
`endif
        end
    endfunction

    // Advance one clock; inputs are stable at the edge, outputs sampled 1 time unit after.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 unit after a rising edge; reset pulse stays clear of the next edge.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        vIn = 4'b0000;
        for (int k = 0; k < 4; k++) dIn[k] = 8'h00;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.dataOut !== Idle) begin
            failures++; $display("FAIL reset_dataOut: got %h expected %h", bus.dataOut, Idle);
        end
        checks++;
        if (bus.validOut !== 1'b0) begin
            failures++; $display("FAIL reset_validOut: got %b expected 0", bus.validOut);
        end
        checks++;
        if (sel !== 2'd0) begin
            failures++; $display("FAIL reset_selectors: got %0d expected 0", sel);
        end
        checks++;
        if (bus.syncDone !== 1'b0) begin
            failures++; $display("FAIL reset_syncDone: got %b expected 0", bus.syncDone);
        end
        checks++;
        if (rdy !== 4'b0000) begin
            failures++; $display("FAIL reset_readyIn: got %b expected 0000", rdy);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_sync();
        do_reset();
        vIn = 4'b1111;
        dIn[0] = 8'h10; dIn[1] = 8'h20; dIn[2] = 8'h30; dIn[3] = 8'h40;
        for (int c = 1; c <= int'(SyncLen); c++) begin
            checks++;
            if (rdy !== 4'b0000 || bus.dataOut !== Idle || bus.validOut !== 1'b0) begin
                failures++;
                $display("FAIL sync_idle c=%0d: got rdy=%b data=%h valid=%b expected 0000 %h 0",
                         c, rdy, bus.dataOut, bus.validOut, Idle);
            end
            tick();
            checks++;
            if (bus.syncDone !== (c == int'(SyncLen))) begin
                failures++;
                $display("FAIL sync_done c=%0d: got %b expected %b", c, bus.syncDone,
                         c == int'(SyncLen));
            end
        end
        checks++;
        if (rdy !== 4'b1111) begin
            failures++; $display("FAIL sync_open_ready: got %b expected 1111", rdy);
        end
        tick();
        checks++;
        if (bus.validOut !== 1'b0) begin
            failures++; $display("FAIL sync_capture_cycle: got valid=%b expected 0", bus.validOut);
        end
        tick();
        checks++;
        if (bus.validOut !== 1'b1 || bus.dataOut !== 8'h10 || sel !== 2'd0) begin
            failures++;
            $display("FAIL sync_first_byte: got %b/%h/%0d expected 1/10/0",
                     bus.validOut, bus.dataOut, sel);
        end
    endtask

    task automatic test_all_lanes();
        logic [7:0] exp [4];
        exp[0] = 8'h10; exp[1] = 8'h20; exp[2] = 8'h30; exp[3] = 8'h40;
        do_reset();
        vIn = 4'b1111;
        for (int k = 0; k < 4; k++) dIn[k] = exp[k];
        repeat (SyncLen + 1) tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rdy !== 4'(1 << (i % 4))) begin
                failures++;
                $display("FAIL all_lanes_ready i=%0d: got %b expected %b", i, rdy,
                         4'(1 << (i % 4)));
            end
            tick();
            checks++;
            if (bus.validOut !== 1'b1 || bus.dataOut !== exp[i % 4] || sel !== 2'(i % 4)) begin
                failures++;
                $display("FAIL all_lanes i=%0d: got %b/%h/%0d expected 1/%h/%0d", i,
                         bus.validOut, bus.dataOut, sel, exp[i % 4], i % 4);
            end
        end
    endtask

    task automatic test_single_lane();
        do_reset();
        vIn = 4'b0100;
        for (int k = 0; k < 4; k++) dIn[k] = 8'h00;
        repeat (SyncLen) tick();
        tick();
        dIn[2] = 8'h01;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (rdy[2] !== 1'b1) begin
                failures++; $display("FAIL single_ready j=%0d: got %b expected 1", j, rdy[2]);
            end
            tick();
            dIn[2] = 8'(j + 2);
            checks++;
            if (bus.validOut !== 1'b1 || bus.dataOut !== 8'(j) || sel !== 2'd2) begin
                failures++;
                $display("FAIL single_lane j=%0d: got %b/%h/%0d expected 1/%h/2", j,
                         bus.validOut, bus.dataOut, sel, 8'(j));
            end
        end
    endtask

    task automatic test_two_lanes();
        int expLane;
        do_reset();
        vIn = 4'b0011;
        dIn[0] = 8'hA0; dIn[1] = 8'hB1; dIn[2] = 8'h00; dIn[3] = 8'h00;
        repeat (SyncLen + 1) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef SCHED_BURST_EN
            expLane = (i / int'(BurstMax)) % 2;
`else
            expLane = i % 2;
`endif
            checks++;
            if (sel !== 2'(expLane) || bus.dataOut !== dIn[expLane]) begin
                failures++;
                $display("FAIL two_lanes i=%0d: got lane %0d data %h expected lane %0d data %h",
                         i, sel, bus.dataOut, expLane, dIn[expLane]);
            end
        end
    endtask

    task automatic test_idle_after_lane1();
        do_reset();
        vIn = 4'b0000;
        repeat (SyncLen) tick();
        vIn = 4'b0010;
        dIn[1] = 8'h5A;
        tick();
        vIn = 4'b0000;
        tick();
        checks++;
        if (bus.validOut !== 1'b1 || bus.dataOut !== 8'h5A || sel !== 2'd1) begin
            failures++;
            $display("FAIL idle_last_grant: got %b/%h/%0d expected 1/5a/1",
                     bus.validOut, bus.dataOut, sel);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.validOut !== 1'b0 || bus.dataOut !== Idle || sel !== 2'd1 ||
                rdy !== 4'b1111) begin
                failures++;
                $display("FAIL idle_hold i=%0d: got %b/%h/%0d rdy=%b expected 0/%h/1 1111", i,
                         bus.validOut, bus.dataOut, sel, rdy, Idle);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        vIn = 4'b0000;
        repeat (SyncLen) tick();
        vIn = 4'b1000;
        dIn[3] = 8'hAA;
        repeat (4) tick();
        checks++;
        if (bus.validOut !== 1'b1 || bus.dataOut !== 8'hAA || sel !== 2'd3) begin
            failures++;
            $display("FAIL mid_pre: got %b/%h/%0d expected 1/aa/3",
                     bus.validOut, bus.dataOut, sel);
        end
        vIn = 4'b0000;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.validOut !== 1'b0 || bus.dataOut !== Idle || sel !== 2'd0 ||
            bus.syncDone !== 1'b0 || rdy !== 4'b0000) begin
            failures++;
            $display("FAIL mid_async: got %b/%h/%0d done=%b rdy=%b expected 0/%h/0 0 0000",
                     bus.validOut, bus.dataOut, sel, bus.syncDone, rdy, Idle);
        end
        #1;
        reset = 1'b1;
        for (int i = 0; i < int'(SyncLen) + 6; i++) begin
            tick();
            checks++;
            if (bus.validOut !== 1'b0 || bus.dataOut === 8'hAA) begin
                failures++;
                $display("FAIL mid_discard i=%0d: got %b/%h expected 0/%h", i,
                         bus.validOut, bus.dataOut, Idle);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] expRdy;
        logic [3:0] acc;
        int dens;
        do_reset();
        vIn = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            dens = (i < 200) ? 90 : ((i < 400) ? 35 : 65);
            expRdy = model_ready();
            checks++;
            if (rdy !== expRdy) begin
                failures++; $display("FAIL rand_ready i=%0d: got %b expected %b", i, rdy, expRdy);
            end
            acc = vIn & expRdy;
            tick();
            checks++;
            if (bus.validOut !== mValid || bus.dataOut !== mData) begin
                failures++;
                $display("FAIL rand_out i=%0d: got %b/%h expected %b/%h", i,
                         bus.validOut, bus.dataOut, mValid, mData);
            end
            checks++;
            if (sel !== 2'(mSel) || bus.syncDone !== mDone) begin
                failures++;
                $display("FAIL rand_sel i=%0d: got %0d done=%b expected %0d done=%b", i,
                         sel, bus.syncDone, mSel, mDone);
            end
            // Sources keep an unaccepted byte stable; otherwise pick a new offer.
            for (int k = 0; k < 4; k++) begin
                if (acc[k] || !vIn[k]) begin
                    vIn[k] = ($urandom_range(0, 99) < dens);
                    dIn[k] = 8'($urandom);
                end
            end
        end
    endtask

    initial begin
        vIn = 4'b0000;
        for (int k = 0; k < 4; k++) dIn[k] = 8'h00;
        #3;
        test_reset();
        test_sync();
        test_all_lanes();
        test_single_lane();
        test_two_lanes();
        test_idle_after_lane1();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
